// File: rtl/torus_mm_sched.sv
// Cannon's-algorithm sequencer for the N x N torus multiply array: clears accumulators,
// skews A/B, then runs N rounds of multiply / accumulate / rotate via the STM-EOM handshake.
module torus_mm_sched #(
    parameter int N      = 4,
    parameter int STEP_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              EOM_ALL,
    output logic              STM,
    output logic              ACC_CLR,
    output logic              ACC_EN,
    output logic [N-1:0]      SHA,
    output logic [N-1:0]      SHB,
    output logic [STEP_W-1:0] STEP,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [2:0] {
        IDLE, CLR, SKEW, MSTART, MWAIT, ACC, SHIFT, FIN
    } state_t;

    localparam logic [STEP_W-1:0] K_SKEW_LAST = STEP_W'((N > 1) ? N - 2 : 0);
    localparam logic [STEP_W-1:0] K_LAST      = STEP_W'(N - 1);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   k_q, k_d;
    logic                first_q, first_d;
    logic                stm_q, stm_d;
    logic                clr_q, clr_d;
    logic                acc_q, acc_d;
    logic [N-1:0]        sha_q, sha_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        first_d = 1'b0;
        case (state_q)
            IDLE:   if (START) state_d = CLR;
            CLR: begin
                k_d     = '0;
                state_d = (N > 1) ? SKEW : MSTART;
            end
            SKEW: begin
                if (k_q == K_SKEW_LAST) begin
                    k_d     = '0;
                    state_d = MSTART;
                end else begin
                    k_d = k_q + STEP_W'(1);
                end
            end
            MSTART: begin
                first_d = 1'b1;
                state_d = MWAIT;
            end
            // The first MWAIT cycle may still see EOM from before STM reached the PEs.
            MWAIT:  if (!first_q && EOM_ALL) state_d = ACC;
            ACC:    state_d = (k_q == K_LAST) ? FIN : SHIFT;
            SHIFT: begin
                k_d     = k_q + STEP_W'(1);
                state_d = MSTART;
            end
            FIN: begin
                k_d     = '0;
                state_d = IDLE;
            end
            default: begin
                k_d     = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        stm_d  = (state_d == MSTART);
        clr_d  = (state_d == CLR);
        acc_d  = (state_d == ACC);
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
        sha_d  = '0;
        for (int i = 0; i < N; i++) begin
            if (state_d == SKEW)
                sha_d[i] = (i > int'(k_d));
            else if (state_d == SHIFT)
                sha_d[i] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            k_q     <= '0;
            first_q <= 1'b0;
            stm_q   <= 1'b0;
            clr_q   <= 1'b0;
            acc_q   <= 1'b0;
            sha_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            first_q <= first_d;
            stm_q   <= stm_d;
            clr_q   <= clr_d;
            acc_q   <= acc_d;
            sha_q   <= sha_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Row and column enables follow identical patterns, so one register drives both.
    assign STM     = stm_q;
    assign ACC_CLR = clr_q;
    assign ACC_EN  = acc_q;
    assign SHA     = sha_q;
    assign SHB     = sha_q;
    assign STEP    = k_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_torus_mm_sched.sv
// Scoreboard bench for torus_mm_sched: an N=4 instance with a PE EOM model and an N=1 instance.
module tb_torus_mm_sched;

    typedef struct packed {
        logic       clr;
        logic       stm;
        logic       acc;
        logic       done;
        logic [3:0] sha;
        logic [3:0] shb;
        logic [3:0] step;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START4 = 1'b0, START1 = 1'b0;
    logic       eom4 = 1'b1, eom1 = 1'b1;
    logic       STM4, CLR4, ACC4, BUSY4, DONE4;
    logic [3:0] SHA4, SHB4, STEP4;
    logic       STM1, CLR1, ACC1, BUSY1, DONE1;
    logic [0:0] SHA1, SHB1;
    logic [3:0] STEP1;

    int assertCount = 0;
    int failCount   = 0;
    ev_t q4[$];
    ev_t q1[$];
    int cycleNo = 0;
    int run4 = 0, lastRun4 = 0, runsDone4 = 0;
    int run1 = 0, lastRun1 = 0, runsDone1 = 0;
    int lastDone4 = 0, lastClr4 = 0, doneCount4 = 0, clrCount4 = 0;
    int lowCnt = 0;
    int stallStep = 15;
    bit eomHigh = 1'b0;

    always #5 CLK = ~CLK;

    torus_mm_sched #(.N(4), .STEP_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .START(START4), .EOM_ALL(eom4),
        .STM(STM4), .ACC_CLR(CLR4), .ACC_EN(ACC4), .SHA(SHA4), .SHB(SHB4),
        .STEP(STEP4), .BUSY(BUSY4), .DONE(DONE4)
    );

    torus_mm_sched #(.N(1), .STEP_W(4)) dut1 (
        .CLK(CLK), .RST(RST), .START(START1), .EOM_ALL(eom1),
        .STM(STM1), .ACC_CLR(CLR1), .ACC_EN(ACC1), .SHA(SHA1), .SHB(SHB1),
        .STEP(STEP1), .BUSY(BUSY1), .DONE(DONE1)
    );

    function automatic ev_t mk(input logic c, input logic s, input logic a, input logic d,
                               input logic [3:0] sh, input logic [3:0] st);
        ev_t e;
        e = '{clr: c, stm: s, acc: a, done: d, sha: sh, shb: sh, step: st};
        return e;
    endfunction

    // PE model: EOM drops after each STM and is sampled low for 3 edges (20 in the stall round).
    always @(negedge CLK) begin
        if (eomHigh) begin
            eom4 = 1'b1;
            lowCnt = 0;
        end else if (STM4) begin
            eom4 = 1'b0;
            lowCnt = (int'(STEP4) == stallStep) ? 21 : 4;
        end else if (lowCnt > 0) begin
            lowCnt = lowCnt - 1;
            if (lowCnt == 0) eom4 = 1'b1;
        end
    end

    // Monitors: every active output cycle pops one expected event; BUSY runs are measured.
    always @(negedge CLK) begin
        ev_t obs, exp;
        cycleNo++;
        if (BUSY4) run4++;
        else if (run4 != 0) begin lastRun4 = run4; run4 = 0; runsDone4++; end
        if (BUSY1) run1++;
        else if (run1 != 0) begin lastRun1 = run1; run1 = 0; runsDone1++; end
        obs = '{clr: CLR4, stm: STM4, acc: ACC4, done: DONE4, sha: SHA4, shb: SHB4, step: STEP4};
        if (CLR4 || STM4 || ACC4 || DONE4 || (SHA4 != 4'd0) || (SHB4 != 4'd0)) begin
            if (CLR4) begin lastClr4 = cycleNo; clrCount4++; end
            if (DONE4) begin lastDone4 = cycleNo; doneCount4++; end
            exp = (q4.size() != 0) ? q4.pop_front() : ev_t'(0);
            assertCount++;
            assert (obs === exp) else begin
                failCount++;
                $error("[TB] FAIL ev4 cycle %0d observed=%h expected=%h", cycleNo, obs, exp);
            end
        end
        obs = '{clr: CLR1, stm: STM1, acc: ACC1, done: DONE1, sha: {3'b0, SHA1}, shb: {3'b0, SHB1}, step: STEP1};
        if (CLR1 || STM1 || ACC1 || DONE1 || SHA1[0] || SHB1[0]) begin
            exp = (q1.size() != 0) ? q1.pop_front() : ev_t'(0);
            assertCount++;
            assert (obs === exp) else begin
                failCount++;
                $error("[TB] FAIL ev1 cycle %0d observed=%h expected=%h", cycleNo, obs, exp);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit which4);
        @(posedge CLK); #1;
        if (which4) START4 = 1'b1; else START1 = 1'b1;
        @(posedge CLK); #1;
        if (which4) START4 = 1'b0; else START1 = 1'b0;
    endtask

    task automatic pushProduct4();
        q4.push_back(mk(1, 0, 0, 0, 4'h0, 4'd0));
        for (int k = 0; k < 3; k++)
            q4.push_back(mk(0, 0, 0, 0, (4'hF << (k + 1)), 4'(k)));
        for (int r = 0; r < 4; r++) begin
            q4.push_back(mk(0, 1, 0, 0, 4'h0, 4'(r)));
            q4.push_back(mk(0, 0, 1, 0, 4'h0, 4'(r)));
            if (r < 3) q4.push_back(mk(0, 0, 0, 0, 4'hF, 4'(r)));
        end
        q4.push_back(mk(0, 0, 0, 1, 4'h0, 4'd3));
    endtask

    task automatic waitStm(input int step);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge CLK);
            if (STM4 && int'(STEP4) == step) found = 1'b1;
        end
        checkOutput($sformatf("stmSeen%0d", step), 32'(found), 32'd1);
    endtask

    task automatic waitRun(input int target);
        for (int i = 0; i < 500 && runsDone4 < target; i++) @(negedge CLK);
        checkOutput("runDone", 32'(runsDone4), 32'(target));
    endtask

    initial begin
        int doneBefore, clrBefore;
        #2;
        checkOutput("resetOut", {STM4, CLR4, ACC4, SHA4, SHB4, STEP4, BUSY4, DONE4}, 32'd0);
        @(posedge CLK); #1 RST = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("idleBusy", 32'(BUSY4), 32'd0);

        $display("[TB] nominal product");
        pushProduct4();
        applyStimulus(1'b1);
        waitRun(1);
        checkOutput("nomBusyLen", 32'(lastRun4), 32'd32);
        checkOutput("nomQueue", 32'(q4.size()), 32'd0);

        $display("[TB] EOM stall in round 2");
        stallStep = 1;
        pushProduct4();
        applyStimulus(1'b1);
        waitStm(1);
        repeat (10) @(negedge CLK);
        checkOutput("stallStep", 32'(STEP4), 32'd1);
        checkOutput("stallStm", 32'(STM4), 32'd0);
        checkOutput("stallBusy", 32'(BUSY4), 32'd1);
        waitRun(2);
        checkOutput("stallBusyLen", 32'(lastRun4), 32'd49);
        checkOutput("stallQueue", 32'(q4.size()), 32'd0);
        stallStep = 15;

        $display("[TB] early EOM");
        eomHigh = 1'b1;
        pushProduct4();
        applyStimulus(1'b1);
        waitRun(3);
        checkOutput("earlyBusyLen", 32'(lastRun4), 32'd24);
        eomHigh = 1'b0;

        $display("[TB] START while busy");
        pushProduct4();
        applyStimulus(1'b1);
        waitStm(0);
        applyStimulus(1'b1);
        waitStm(3);
        applyStimulus(1'b1);
        doneBefore = doneCount4;
        clrBefore = clrCount4;
        pushProduct4();
        START4 = 1'b1;
        for (int i = 0; i < 100 && clrCount4 == clrBefore; i++) @(negedge CLK);
        @(posedge CLK); #1 START4 = 1'b0;
        checkOutput("heldClr", 32'(clrCount4), 32'(clrBefore + 1));
        checkOutput("oneDone", 32'(doneCount4), 32'(doneBefore + 1));
        checkOutput("clrAfterDone", 32'(lastClr4 - lastDone4), 32'd2);
        checkOutput("busyRunLen", 32'(lastRun4), 32'd32);
        waitRun(5);
        checkOutput("heldRunLen", 32'(lastRun4), 32'd32);
        checkOutput("heldQueue", 32'(q4.size()), 32'd0);

        $display("[TB] N=1 product");
        q1.push_back(mk(1, 0, 0, 0, 4'h0, 4'd0));
        q1.push_back(mk(0, 1, 0, 0, 4'h0, 4'd0));
        q1.push_back(mk(0, 0, 1, 0, 4'h0, 4'd0));
        q1.push_back(mk(0, 0, 0, 1, 4'h0, 4'd0));
        applyStimulus(1'b0);
        for (int i = 0; i < 100 && runsDone1 < 1; i++) @(negedge CLK);
        checkOutput("n1Run", 32'(runsDone1), 32'd1);
        checkOutput("n1BusyLen", 32'(lastRun1), 32'd6);
        checkOutput("n1Queue", 32'(q1.size()), 32'd0);

        $display("[TB] reset mid-MWAIT");
        pushProduct4();
        applyStimulus(1'b1);
        waitStm(0);
        @(negedge CLK);
        #3 RST = 1'b0;
        #1;
        checkOutput("midReset", {STM4, CLR4, ACC4, SHA4, SHB4, STEP4, BUSY4, DONE4}, 32'd0);
        q4.delete();
        @(posedge CLK); #1 RST = 1'b1;
        repeat (6) @(negedge CLK);
        checkOutput("postResetBusy", 32'(BUSY4), 32'd0);
        checkOutput("postResetStep", 32'(STEP4), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
